rx_frame_commit_ctrl: RTL and testbench

Store-and-forward commit controller downstream of the RX MAC. Writes the per-byte receive stream into a circular buffer speculatively and waits a bounded window after frame end for the MAC's invalid-frame pulse. It then either commits the frame or rolls the write pointer back. Committed frames are drained on a valid/ready byte stream with an end-of-frame marker, so consumers never see bytes of a frame that failed CRC or parsing checks.

---
 rtl/rx_frame_commit_ctrl.sv | 171 +++++++++++++++++
 tb/tb_rx_frame_commit_ctrl.sv | 394 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_frame_commit_ctrl.sv
// rx_frame_commit_ctrl
//   Store-and-forward commit controller behind the RX MAC. Received bytes are
//   written speculatively into a circular buffer. After the frame ends, the
//   controller waits a bounded window for the MAC's invalid-frame verdict.
//   It then commits the frame (commit_ptr <- wr_ptr) or rolls it back
//   (wr_ptr <- commit_ptr). Only committed bytes are drained.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   rx_data_i         receive byte from the MAC
//   rx_valid_i        byte qualifier; one contiguous high run per frame
//   invalid_frame_i   single-cycle verdict pulse marking the frame bad
//   m_data_o          drained byte
//   m_valid_o         m_data_o / m_last_o valid
//   m_last_o          final byte of frame
//   m_ready_i         consumer accepts when m_valid_o && m_ready_i
//   frames_ok_o       committed-frame count, saturating
//   frames_dropped_o  discarded-frame count, saturating
//   overflow_o        pulse on the first byte of a frame rejected for space
module rx_frame_commit_ctrl #(
  parameter int unsigned ADDR_W       = 11,
  parameter int unsigned VERDICT_WAIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  input  logic        invalid_frame_i,
  output logic [7:0]  m_data_o,
  output logic        m_valid_o,
  output logic        m_last_o,
  input  logic        m_ready_i,
  output logic [15:0] frames_ok_o,
  output logic [15:0] frames_dropped_o,
  output logic        overflow_o
);

  localparam int unsigned     DEPTH   = 1 << ADDR_W;
  localparam logic [ADDR_W:0] PTR_ONE = 1;

  typedef enum logic [1:0] {IDLE, RECV, CHECK, SKIP} state_t;

  state_t          state;
  logic [ADDR_W:0] wr_ptr;
  logic [ADDR_W:0] commit_ptr;
  logic [ADDR_W:0] rd_ptr;
  logic [8:0]      mem [DEPTH];
  logic [7:0]      hold_data;
  logic            bad;
  logic            ovf;
  logic            saw_rx;
  logic [3:0]      cnt;
  logic [ADDR_W:0] used;
  logic            full;
  logic            wr_en;
  logic            rd_load;

  // Every RECV cycle is a write attempt: the held byte goes out either because
  // a newer byte arrived (last=0) or because the frame just ended (last=1).
  // Space is judged on the registered rd_ptr, so a same-cycle read does not
  // free room for this write.
  always_comb begin
    used       = wr_ptr - rd_ptr;
    full       = used[ADDR_W];
    overflow_o = (state == RECV) && full && !ovf;
    wr_en      = (state == RECV) && !full && !ovf;
    rd_load    = (rd_ptr != commit_ptr) && (!m_valid_o || m_ready_i);
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr[ADDR_W-1:0]] <= {!rx_valid_i, hold_data};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      wr_ptr           <= '0;
      commit_ptr       <= '0;
      hold_data        <= '0;
      bad              <= 1'b0;
      ovf              <= 1'b0;
      saw_rx           <= 1'b0;
      cnt              <= '0;
      frames_ok_o      <= '0;
      frames_dropped_o <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      case (state)
        IDLE: begin
          if (rx_valid_i) begin
            hold_data <= rx_data_i;
            bad       <= invalid_frame_i;
            ovf       <= 1'b0;
            state     <= RECV;
          end
        end
        RECV: begin
          if (invalid_frame_i || overflow_o) begin
            bad <= 1'b1;
          end
          if (overflow_o) begin
            ovf <= 1'b1;
          end
          if (rx_valid_i) begin
            hold_data <= rx_data_i;
          end else begin
            cnt    <= 4'(VERDICT_WAIT);
            saw_rx <= 1'b0;
            state  <= CHECK;
          end
        end
        CHECK: begin
          if (rx_valid_i) begin
            saw_rx <= 1'b1;
          end
          // The verdict cycle itself no longer honours invalid_frame_i.
          if (cnt == '0) begin
            if (bad) begin
              wr_ptr <= commit_ptr;
              if (frames_dropped_o != '1) begin
                frames_dropped_o <= frames_dropped_o + 16'd1;
              end
            end else begin
              commit_ptr <= wr_ptr;
              if (frames_ok_o != '1) begin
                frames_ok_o <= frames_ok_o + 16'd1;
              end
            end
            state <= (saw_rx || rx_valid_i) ? SKIP : IDLE;
          end else begin
            if (invalid_frame_i) begin
              bad <= 1'b1;
            end
            cnt <= cnt - 4'd1;
          end
        end
        SKIP: begin
          if (!rx_valid_i) begin
            if (frames_dropped_o != '1) begin
              frames_dropped_o <= frames_dropped_o + 16'd1;
            end
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // First-word-fall-through output register, refilled whenever it is empty
  // or being consumed this cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr    <= '0;
      m_valid_o <= 1'b0;
      m_last_o  <= 1'b0;
      m_data_o  <= '0;
    end else if (rd_load) begin
      {m_last_o, m_data_o} <= mem[rd_ptr[ADDR_W-1:0]];
      m_valid_o            <= 1'b1;
      rd_ptr               <= rd_ptr + PTR_ONE;
    end else if (m_ready_i) begin
      m_valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rx_frame_commit_ctrl.sv
module tb_rx_frame_commit_ctrl;

  localparam int VW_A = 4;
  localparam int VW_B = 8;
  localparam int NR   = 30;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst      [2];
  logic [7:0]  rx_data  [2];
  logic        rx_valid [2];
  logic        invalid  [2];
  logic        m_ready  [2] = '{1'b0, 1'b0};
  logic [7:0]  m_data   [2];
  logic        m_valid  [2];
  logic        m_last   [2];
  logic [15:0] f_ok     [2];
  logic [15:0] f_drop   [2];
  logic        ovf      [2];

  int errors = 0;
  int checks = 0;
  int rdy_mode [2] = '{0, 0};

  logic [8:0] q0 [$];
  logic [8:0] q1 [$];

  rx_frame_commit_ctrl #(.ADDR_W(11), .VERDICT_WAIT(VW_A)) dut_a (
    .clk(clk), .rst(rst[0]), .rx_data_i(rx_data[0]), .rx_valid_i(rx_valid[0]),
    .invalid_frame_i(invalid[0]), .m_data_o(m_data[0]), .m_valid_o(m_valid[0]),
    .m_last_o(m_last[0]), .m_ready_i(m_ready[0]), .frames_ok_o(f_ok[0]),
    .frames_dropped_o(f_drop[0]), .overflow_o(ovf[0])
  );

  rx_frame_commit_ctrl #(.ADDR_W(6), .VERDICT_WAIT(VW_B)) dut_b (
    .clk(clk), .rst(rst[1]), .rx_data_i(rx_data[1]), .rx_valid_i(rx_valid[1]),
    .invalid_frame_i(invalid[1]), .m_data_o(m_data[1]), .m_valid_o(m_valid[1]),
    .m_last_o(m_last[1]), .m_ready_i(m_ready[1]), .frames_ok_o(f_ok[1]),
    .frames_dropped_o(f_drop[1]), .overflow_o(ovf[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int qsize(input int sel);
    if (sel == 0) return q0.size();
    return q1.size();
  endfunction

  task automatic push_byte(input int sel, input logic [8:0] v);
    if (sel == 0) q0.push_back(v);
    else q1.push_back(v);
  endtask

  task automatic push_frame(input int sel, input int len, input int first);
    for (int b = 0; b < len; b++) push_byte(sel, {b == len - 1, 8'(first + b)});
  endtask

  // Consumer ready pattern: 0 low, 1 high, 2 toggling, 3 random.
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < 2; i++) begin
      case (rdy_mode[i])
        0: m_ready[i] = 1'b0;
        1: m_ready[i] = 1'b1;
        2: m_ready[i] = ~m_ready[i];
        default: m_ready[i] = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Output scoreboard plus hold-stability while stalled.
  logic       prev_stall [2] = '{1'b0, 1'b0};
  logic [8:0] prev_out   [2];
  always @(negedge clk) begin
    logic [8:0] e;
    for (int i = 0; i < 2; i++) begin
      if (rst[i]) begin
        prev_stall[i] = 1'b0;
      end else begin
        if (prev_stall[i])
          check("stall_hold", {m_valid[i], m_last[i], m_data[i]}, {1'b1, prev_out[i]});
        if (m_valid[i] && m_ready[i]) begin
          if (qsize(i) == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_byte dut%0d: got %03h expected none at %0t",
                     i, {m_last[i], m_data[i]}, $time);
          end else begin
            if (i == 0) e = q0.pop_front();
            else e = q1.pop_front();
            check(i == 0 ? "out_byte_a" : "out_byte_b", {m_last[i], m_data[i]}, e);
          end
        end
        prev_stall[i] = m_valid[i] && !m_ready[i];
        prev_out[i]   = {m_last[i], m_data[i]};
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int sel, input logic v, input logic [7:0] d, input logic inv);
    rx_valid[sel] = v;
    rx_data[sel]  = d;
    invalid[sel]  = inv;
  endtask

  task automatic reset_dut(input int sel);
    rst[sel] = 1'b1;
    drive(sel, 1'b0, 8'h00, 1'b0);
    repeat (2) cyc();
    rst[sel] = 1'b0;
    if (sel == 0) q0.delete();
    else q1.delete();
    repeat (2) cyc();
  endtask

  // Frame of len bytes first, first+1, ...; pulse is the invalid_frame_i
  // offset from the first byte (-1 none); gap low cycles follow.
  task automatic send(input int sel, input int len, input int first, input int pulse, input int gap);
    for (int b = 0; b < len; b++) begin
      drive(sel, 1'b1, 8'(first + b), pulse == b);
      cyc();
    end
    for (int g = 0; g < gap; g++) begin
      drive(sel, 1'b0, 8'h00, pulse == len + g);
      cyc();
    end
    drive(sel, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic wait_drain(input int sel, input string name);
    int n = 0;
    while (qsize(sel) != 0 && n < 5000) begin
      cyc();
      n++;
    end
    check(name, n < 5000, 1);
    repeat (20) cyc();
  endtask

  typedef struct {
    int len;
    int first;
    int pulse;
    int gap;
    bit keep;
  } row_t;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    row_t tbl [8];
    int   eok;
    int   edrop;
    int   r_len [NR];
    int   r_gap [NR];
    int   r_pul [NR];
    int   r_s   [NR];
    int   r_p   [NR];
    bit   r_acc [NR];
    logic [7:0] r_bytes [$];
    int   t;
    int   idx;
    bit   bad;

    // Verdict window boundaries on the VERDICT_WAIT=4 instance.
    tbl[0] = '{30, 'h80, 32, 8, 1'b0};  // invalid at E+2
    tbl[1] = '{60, 'h10, -1, 8, 1'b1};
    tbl[2] = '{17, 'h20, 21, 8, 1'b0};  // invalid at E+VERDICT_WAIT
    tbl[3] = '{17, 'h40, 22, 8, 1'b1};  // invalid one cycle too late
    tbl[4] = '{9,  'h60, 0,  8, 1'b0};  // invalid with first byte
    tbl[5] = '{1,  'h70, -1, 8, 1'b1};  // single-byte frame
    tbl[6] = '{12, 'h90, 5,  8, 1'b0};
    tbl[7] = '{2,  'hA0, -1, 8, 1'b1};

    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1;
      drive(i, 1'b0, 8'h00, 1'b0);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("rst_valid", m_valid[i], 0);
      check("rst_last", m_last[i], 0);
      check("rst_data", m_data[i], 0);
      check("rst_ok", f_ok[i], 0);
      check("rst_drop", f_drop[i], 0);
      check("rst_ovf", ovf[i], 0);
    end
    cyc();
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    repeat (2) cyc();

    // Good frame: exact latency and an unbroken 64-byte burst.
    rdy_mode[0] = 1;
    cyc();
    push_frame(0, 64, 0);
    send(0, 64, 0, -1, 0);
    repeat (VW_A + 2) cyc();
    @(negedge clk);
    check("good_valid_early", m_valid[0], 0);
    cyc();
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      check("good_burst_valid", m_valid[0], 1);
      cyc();
    end
    @(negedge clk);
    check("good_burst_end", m_valid[0], 0);
    check("good_ok", f_ok[0], 1);
    check("good_drop", f_drop[0], 0);
    check("good_q_empty", qsize(0), 0);

    // Table of verdict timings.
    reset_dut(0);
    eok = 0;
    edrop = 0;
    for (int r = 0; r < 8; r++) begin
      if (tbl[r].keep) begin
        push_frame(0, tbl[r].len, tbl[r].first);
        eok++;
      end else begin
        edrop++;
      end
      send(0, tbl[r].len, tbl[r].first, tbl[r].pulse, tbl[r].gap);
      check("tbl_ok", f_ok[0], eok);
      check("tbl_drop", f_drop[0], edrop);
    end
    wait_drain(0, "tbl_drain");

    // Backpressure: ready toggles every cycle.
    reset_dut(0);
    rdy_mode[0] = 2;
    cyc();
    push_frame(0, 23, 'h30);
    send(0, 23, 'h30, -1, 7);
    push_frame(0, 41, 'h55);
    send(0, 41, 'h55, -1, 7);
    wait_drain(0, "bp_drain");
    check("bp_ok", f_ok[0], 2);
    check("bp_drop", f_drop[0], 0);

    // Reset while a frame is arriving and a committed frame is stalled.
    rdy_mode[0] = 0;
    cyc();
    push_frame(0, 16, 'hE0);
    send(0, 16, 'hE0, -1, 10);
    t = 0;
    while (!m_valid[0] && t < 30) begin
      cyc();
      t++;
    end
    check("pre_rst_valid", m_valid[0], 1);
    check("pre_rst_ok", f_ok[0], 3);
    for (int b = 0; b < 20; b++) begin
      drive(0, 1'b1, 8'(b), 1'b0);
      cyc();
    end
    drive(0, 1'b1, 8'd20, 1'b0);
    rst[0] = 1'b1;
    #1;
    check("midrst_valid", m_valid[0], 0);
    check("midrst_last", m_last[0], 0);
    check("midrst_data", m_data[0], 0);
    check("midrst_ok", f_ok[0], 0);
    check("midrst_drop", f_drop[0], 0);
    check("midrst_ovf", ovf[0], 0);
    q0.delete();
    drive(0, 1'b0, 8'h00, 1'b0);
    repeat (2) cyc();
    rst[0] = 1'b0;
    rdy_mode[0] = 1;
    repeat (2) cyc();
    push_frame(0, 64, 'h07);
    send(0, 64, 'h07, -1, 8);
    wait_drain(0, "postrst_drain");
    check("postrst_ok", f_ok[0], 1);
    check("postrst_drop", f_drop[0], 0);

    // Overflow on the 64-entry instance with the consumer stalled.
    reset_dut(1);
    rdy_mode[1] = 0;
    cyc();
    for (int k = 0; k < 100; k++) begin
      drive(1, 1'b1, 8'(k), 1'b0);
      @(negedge clk);
      check("ovf_pulse", ovf[1], k == 65);
      cyc();
    end
    drive(1, 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    check("ovf_at_end", ovf[1], 0);
    cyc();
    for (int k = 0; k < VW_B + 4; k++) begin
      @(negedge clk);
      check("ovf_no_output", m_valid[1], 0);
      cyc();
    end
    check("ovf_drop", f_drop[1], 1);
    check("ovf_ok", f_ok[1], 0);

    // Frames starting inside the verdict window (VERDICT_WAIT=8).
    reset_dut(1);
    rdy_mode[1] = 1;
    cyc();
    push_frame(1, 20, 'h40);
    send(1, 20, 'h40, -1, 3);     // next frame starts at E+3
    send(1, 10, 'hA0, -1, 12);
    check("win_ok", f_ok[1], 1);
    check("win_drop", f_drop[1], 1);
    push_frame(1, 12, 'hC0);
    send(1, 12, 'hC0, -1, 10);    // next starts at E+VERDICT_WAIT+2: accepted
    push_frame(1, 5, 'hD0);
    send(1, 5, 'hD0, -1, 9);      // next starts on the verdict cycle: skipped
    send(1, 4, 'hE0, -1, 12);
    wait_drain(1, "win_drain");
    check("win_ok_final", f_ok[1], 3);
    check("win_drop_final", f_drop[1], 2);

    // Randomized frames against a frame-level model.
    reset_dut(0);
    rdy_mode[0] = 3;
    cyc();
    t = 0;
    for (int i = 0; i < NR; i++) begin
      r_len[i] = $urandom_range(1, 40);
      r_gap[i] = $urandom_range(1, 12);
      r_pul[i] = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, r_len[i] + r_gap[i] - 1));
      r_s[i]   = t;
      r_p[i]   = (r_pul[i] < 0) ? -1 : t + r_pul[i];
      t        = t + r_len[i] + r_gap[i];
      for (int b = 0; b < r_len[i]; b++) r_bytes.push_back(8'($urandom));
    end
    eok = 0;
    edrop = 0;
    idx = 0;
    for (int i = 0; i < NR; i++) begin
      r_acc[i] = (i == 0) || !r_acc[i-1] || (r_gap[i-1] > VW_A + 1);
      if (!r_acc[i]) begin
        edrop++;
      end else begin
        bad = 1'b0;
        for (int j = 0; j < NR; j++)
          if (r_p[j] >= r_s[i] && r_p[j] <= r_s[i] + r_len[i] + VW_A) bad = 1'b1;
        if (bad) begin
          edrop++;
        end else begin
          eok++;
          for (int b = 0; b < r_len[i]; b++) push_byte(0, {b == r_len[i] - 1, r_bytes[idx + b]});
        end
      end
      idx += r_len[i];
    end
    idx = 0;
    for (int i = 0; i < NR; i++) begin
      for (int b = 0; b < r_len[i]; b++) begin
        drive(0, 1'b1, r_bytes[idx + b], r_pul[i] == b);
        cyc();
      end
      for (int g = 0; g < r_gap[i]; g++) begin
        drive(0, 1'b0, 8'h00, r_pul[i] == r_len[i] + g);
        cyc();
      end
      idx += r_len[i];
    end
    drive(0, 1'b0, 8'h00, 1'b0);
    rdy_mode[0] = 1;
    wait_drain(0, "rand_drain");
    check("rand_ok", f_ok[0], eok);
    check("rand_drop", f_drop[0], edrop);
    @(negedge clk);
    check("rand_idle_valid", m_valid[0], 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
